corelet_ctrl: RTL and testbench
===============================

CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameter row, default 8, meaning the number of L0 rows / PE rows.
REQ-002 SHALL have parameter col, default 8, meaning the number of PE columns.
REQ-003 SHALL have parameter addr_bw, default 11, meaning the activation/weight SRAM address width.
REQ-004 SHALL have parameter cnt_bw, default 8, meaning the width of the activation count and kij count fields.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that launches a run; accepted only in IDLE.
REQ-008 SHALL have port os_req, input, 1: mode for the run (0 = WS, 1 = OS); sampled on start.
REQ-009 SHALL have port num_act, input, cnt_bw: activation vectors per kij (legal range 1..255); sampled on start.
REQ-010 SHALL have port num_kij, input, cnt_bw: kernel positions per run (legal range 1..255); sampled on start.
REQ-011 SHALL have port w_base, input, addr_bw: weight base address; sampled on start.
REQ-012 SHALL have port x_base, input, addr_bw: activation base address; sampled on start.
REQ-013 SHALL have port l0_full, input, 1: L0 cannot accept a write.
REQ-014 SHALL have port ofifo_valid, input, 1: OFIFO holds at least one complete output row.
REQ-015 SHALL have port inst, output, 34 bits: the corelet instruction word.
  - [0] kernel load; [1] execute; [2] l0_wr; [3] l0_rd; [6] ofifo_rd; [7] mode; [33] sfp acc.
  - All other bits SHALL be 0.
REQ-016 SHALL have port mem_addr, output, addr_bw: SRAM read address.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at the end of a run.

Function
REQ-019 SHALL implement the states IDLE, KLOAD, KPUSH, XLOAD, EXEC, DRAIN and FIN.
REQ-020 IDLE: on start=1, SHALL latch all inputs sampled on start, set kij_cnt=0 and go to KLOAD; start in any other state SHALL be ignored.
REQ-021 KLOAD SHALL write col weight words to L0.
  - On a cycle with l0_full=0: inst[2]=1, and the word counter and mem_addr advance (starting at w_base + kij_cnt*col).
  - On a cycle with l0_full=1: inst[2]=0, with counter and address held.
  - After the col-th write, SHALL go to KPUSH.
REQ-022 KPUSH SHALL assert inst[3]=1 and inst[0]=1 for exactly col+row-1 cycles, then go to XLOAD.
REQ-023 XLOAD SHALL write num_act activation words to L0, starting at x_base + kij_cnt*num_act, with the same l0_full stall rule as KLOAD, then go to EXEC.
REQ-024 EXEC SHALL assert inst[3]=1 and inst[1]=1 for num_act+row+col-2 cycles, then go to DRAIN.
REQ-025 DRAIN SHALL handle OFIFO reads and accumulation as follows.
  - Each cycle with ofifo_valid=1: inst[6]=1 and the read counter increments.
  - inst[33] SHALL be 1 exactly one cycle after each inst[6] pulse (the SFP sees the registered OFIFO output).
  - After num_act reads and the final inst[33]: if kij_cnt==num_kij-1, go to FIN; otherwise increment kij_cnt and go to KLOAD.
REQ-026 In OS mode, DRAIN SHALL be entered only after the final kij; for intermediate kij it is skipped, going EXEC->KLOAD.
REQ-027 FIN SHALL assert done=1 for one cycle, then go to IDLE.
REQ-028 inst[7] SHALL equal the latched mode for the whole run and SHALL be 0 in IDLE.
REQ-029 inst and mem_addr SHALL be registered outputs, with 1-cycle latency from the state/counter update.
REQ-030 Address arithmetic SHALL wrap modulo 2^addr_bw.
REQ-031 num_act=0 or num_kij=0 on start SHALL be treated as 1.

Reset
REQ-032 reset=1 SHALL force IDLE, clear all counters, and set inst=0, mem_addr=0, busy=0 and done=0 on the next edge, including mid-run; any partial run is abandoned.

Configuration
REQ-033 With CORELET_CTRL_OS_EN defined, os_req SHALL be honoured as in REQ-026 and REQ-028.
REQ-034 Without CORELET_CTRL_OS_EN, os_req SHALL be ignored, the mode SHALL be forced to WS, inst[7] SHALL be constantly 0, and no OS skip logic SHALL be synthesised.

Structure
REQ-035 The shared package corelet_pkg SHALL hold:
  - the state enum;
  - the inst bit-position constants (INST_KLOAD=0, INST_EXEC=1, INST_L0_WR=2, INST_L0_RD=3, INST_OFIFO_RD=6, INST_MODE=7, INST_ACC=33);
  - INST_W=34.
REQ-036 One sub-module SHALL exist: corelet_ctrl_cnt, a loadable up-counter with enable and terminal-count flag, instantiated for the word, cycle and kij counters.

Verification
REQ-037 The bench SHALL cover a WS run with row=col=8, num_act=4, num_kij=1, w_base=0, x_base=16.
  - Expected: 8 inst[2] pulses at mem_addr 0..7, then 15 KPUSH cycles, then 4 writes at 16..19, then 18 EXEC cycles.
  - Expected: 4 inst[6] pulses each followed by inst[33], then done high for 1 cycle.
REQ-038 The bench SHALL cover l0_full held high for 3 cycles mid-KLOAD.
  - Expected: inst[2]=0 and mem_addr frozen for those 3 cycles; the total write count is still 8.
REQ-039 The bench SHALL cover num_kij=3 in WS mode.
  - Expected: three KLOAD phases at weight bases 0, 8 and 16, and 12 accumulate pulses in total.
REQ-040 The bench SHALL cover OS mode with CORELET_CTRL_OS_EN defined and num_kij=2.
  - Expected: inst[7]=1 throughout, and DRAIN entered once (after kij 1 only).
REQ-041 The bench SHALL cover reset asserted during EXEC.
  - Expected: next cycle inst=0, busy=0, and no done pulse; a new start then completes normally.
REQ-042 The bench SHALL cover start pulsed while busy and ofifo_valid toggling every other cycle in DRAIN.
  - Expected: the start is ignored, and inst[6] tracks ofifo_valid with exactly num_act reads.

Source files
------------

// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet controller: FSM state encoding and
// the bit positions of the 34-bit corelet instruction word.
package corelet_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KLOAD = 3'd1,
    S_KPUSH = 3'd2,
    S_XLOAD = 3'd3,
    S_EXEC  = 3'd4,
    S_DRAIN = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam int INST_W        = 34;
  localparam int INST_KLOAD    = 0;
  localparam int INST_EXEC     = 1;
  localparam int INST_L0_WR    = 2;
  localparam int INST_L0_RD    = 3;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_MODE     = 7;
  localparam int INST_ACC      = 33;

endpackage

// File: rtl/corelet_ctrl_cnt.sv
// Loadable up-counter with enable. tc is high while the count equals term,
// so a phase ends on the cycle where tc and the enabling event coincide.
module corelet_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority over counting so a phase change always restarts cleanly.
  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = load_val;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet sequencer: per kernel position it loads weights into L0, pushes
// them into the PE array, loads activations, executes, then drains the OFIFO
// into the SFP accumulator. inst and mem_addr are registered one cycle after
// the decision that produces them.
// Optional feature macro: CORELET_CTRL_OS_EN (output-stationary mode; when
// undefined the controller is weight-stationary only and os_req is ignored).
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               os_req,
  input  logic [cnt_bw-1:0]  num_act,
  input  logic [cnt_bw-1:0]  num_kij,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic               l0_full,
  input  logic               ofifo_valid,
  output logic [INST_W-1:0]  inst,
  output logic [addr_bw-1:0] mem_addr,
  output logic               busy,
  output logic               done
);

  // Wide enough for num_act + row + col - 2 execute cycles.
  localparam int CYC_W = cnt_bw + 8;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [cnt_bw-1:0]  num_act_q, num_act_d;
  logic [cnt_bw-1:0]  num_kij_q, num_kij_d;
  // Running read pointers; kij blocks are contiguous so they simply keep counting.
  logic [addr_bw-1:0] w_ptr_q, w_ptr_d;
  logic [addr_bw-1:0] x_ptr_q, x_ptr_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic [addr_bw-1:0] mem_addr_q, mem_addr_d;
  logic               done_q, done_d;

  logic              word_load, word_en, word_tc;
  logic [cnt_bw-1:0] word_term;
  logic              cyc_load, cyc_tc;
  logic [CYC_W-1:0]  cyc_term;
  logic              kij_load, kij_en, kij_tc;

  corelet_ctrl_cnt #(.W(cnt_bw)) u_word_cnt (
    .clk(clk), .reset(reset), .load(word_load), .load_val('0),
    .en(word_en), .term(word_term), .tc(word_tc)
  );

  corelet_ctrl_cnt #(.W(CYC_W)) u_cyc_cnt (
    .clk(clk), .reset(reset), .load(cyc_load), .load_val('0),
    .en(1'b1), .term(cyc_term), .tc(cyc_tc)
  );

  corelet_ctrl_cnt #(.W(cnt_bw)) u_kij_cnt (
    .clk(clk), .reset(reset), .load(kij_load), .load_val('0),
    .en(kij_en), .term(num_kij_q - cnt_bw'(1)), .tc(kij_tc)
  );

  // Next-state, counter control and next output word.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    num_act_d  = num_act_q;
    num_kij_d  = num_kij_q;
    w_ptr_d    = w_ptr_q;
    x_ptr_d    = x_ptr_q;
    mem_addr_d = mem_addr_q;
    inst_d     = '0;
    done_d     = 1'b0;
    word_load  = 1'b0;
    word_en    = 1'b0;
    word_term  = '0;
    cyc_load   = 1'b0;
    cyc_term   = '0;
    kij_load   = 1'b0;
    kij_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef CORELET_CTRL_OS_EN
          mode_d    = os_req;
`else
          // WS-only build: the request is tied off and folds to zero.
          mode_d    = os_req & 1'b0;
`endif
          num_act_d = (num_act == '0) ? cnt_bw'(1) : num_act;
          num_kij_d = (num_kij == '0) ? cnt_bw'(1) : num_kij;
          w_ptr_d   = w_base;
          x_ptr_d   = x_base;
          word_load = 1'b1;
          cyc_load  = 1'b1;
          kij_load  = 1'b1;
          state_d   = S_KLOAD;
        end
      end
      S_KLOAD: begin
        word_term = cnt_bw'(col - 1);
        if (!l0_full) begin
          inst_d[INST_L0_WR] = 1'b1;
          mem_addr_d = w_ptr_q;
          w_ptr_d    = w_ptr_q + addr_bw'(1);
          word_en    = 1'b1;
          if (word_tc) begin
            word_load = 1'b1;
            cyc_load  = 1'b1;
            state_d   = S_KPUSH;
          end
        end
      end
      S_KPUSH: begin
        inst_d[INST_L0_RD] = 1'b1;
        inst_d[INST_KLOAD] = 1'b1;
        cyc_term = CYC_W'(row + col - 2);
        if (cyc_tc) begin
          word_load = 1'b1;
          state_d   = S_XLOAD;
        end
      end
      S_XLOAD: begin
        word_term = num_act_q - cnt_bw'(1);
        if (!l0_full) begin
          inst_d[INST_L0_WR] = 1'b1;
          mem_addr_d = x_ptr_q;
          x_ptr_d    = x_ptr_q + addr_bw'(1);
          word_en    = 1'b1;
          if (word_tc) begin
            cyc_load = 1'b1;
            state_d  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        inst_d[INST_L0_RD] = 1'b1;
        inst_d[INST_EXEC]  = 1'b1;
        cyc_term = CYC_W'(num_act_q) + CYC_W'(row + col - 2) - CYC_W'(1);
        if (cyc_tc) begin
          word_load = 1'b1;
          state_d   = S_DRAIN;
`ifdef CORELET_CTRL_OS_EN
          // OS keeps partial sums in the array until the last kernel position.
          if (mode_q && !kij_tc) begin
            kij_en  = 1'b1;
            state_d = S_KLOAD;
          end
`endif
        end
      end
      S_DRAIN: begin
        // word_tc here means every row has been read; the final read's
        // accumulate pulse is generated on this same decision cycle.
        word_term = num_act_q;
        if (word_tc) begin
          word_load = 1'b1;
          if (kij_tc) begin
            state_d = S_FIN;
          end else begin
            kij_en  = 1'b1;
            state_d = S_KLOAD;
          end
        end else if (ofifo_valid) begin
          inst_d[INST_OFIFO_RD] = 1'b1;
          word_en = 1'b1;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // SFP accumulates the OFIFO word one cycle after it was popped.
    inst_d[INST_ACC]  = inst_q[INST_OFIFO_RD];
    inst_d[INST_MODE] = (state_d != S_IDLE) && mode_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      num_act_q  <= '0;
      num_kij_q  <= '0;
      w_ptr_q    <= '0;
      x_ptr_q    <= '0;
      inst_q     <= '0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      num_act_q  <= num_act_d;
      num_kij_q  <= num_kij_d;
      w_ptr_q    <= w_ptr_d;
      x_ptr_q    <= x_ptr_d;
      inst_q     <= inst_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
    end
  end

  assign inst     = inst_q;
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl (row=col=8, addr_bw=11, cnt_bw=8).
// Honours CORELET_CTRL_OS_EN for the OS-mode expectations.
module tb_corelet_ctrl;
  import corelet_pkg::*;

`ifdef CORELET_CTRL_OS_EN
  localparam bit OS_EN = 1'b1;
`else
  localparam bit OS_EN = 1'b0;
`endif
  localparam logic [33:0] LEGAL = 34'h2_0000_00CF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, start = 1'b0, os_req = 1'b0;
  logic        l0_full = 1'b0, ofifo_valid = 1'b0;
  logic [7:0]  num_act = '0, num_kij = '0;
  logic [10:0] w_base = '0, x_base = '0;
  logic [33:0] inst;
  logic [10:0] mem_addr;
  logic        busy, done;

  corelet_ctrl #(.row(8), .col(8), .addr_bw(11), .cnt_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .os_req(os_req),
    .num_act(num_act), .num_kij(num_kij), .w_base(w_base), .x_base(x_base),
    .l0_full(l0_full), .ofifo_valid(ofifo_valid),
    .inst(inst), .mem_addr(mem_addr), .busy(busy), .done(done)
  );

  int n_tests = 0, n_fail = 0;
  int wq[$], pr[$], er[$];
  string sig;
  int nrd, nacc, ndone, bad_bits, mode_err, acc_err, trk_err;
  int stall_err, stall_gap, post_err, timeout;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  // Launch a run and trace it until done plus three idle samples.
  task automatic run(input bit os, input int na, input int nk, input int wb,
                     input int xb, input int stall_after, input bit toggle,
                     input int restart_at);
    logic [33:0] i;
    string last, c;
    int pcur, ecur, drive_left, stall_left, stall_addr, trig_cyc, post;
    bit prev_rd, prev_v, stalled, exp_mode;
    exp_mode = os & OS_EN;
    wq.delete(); pr.delete(); er.delete();
    sig = ""; last = "";
    nrd = 0; nacc = 0; ndone = 0; bad_bits = 0; mode_err = 0; acc_err = 0;
    trk_err = 0; stall_err = 0; stall_gap = -1; post_err = 0; timeout = 0;
    pcur = 0; ecur = 0; drive_left = 0; stall_left = 0; stall_addr = 0;
    trig_cyc = 0; post = -1; stalled = 0; prev_rd = 0;
    @(negedge clk);
    os_req = os; num_act = na[7:0]; num_kij = nk[7:0];
    w_base = wb[10:0]; x_base = xb[10:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b1;
    prev_v = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i = inst;
      if ((i & ~LEGAL) != '0) bad_bits++;
      if (i[INST_MODE] !== (busy & exp_mode)) mode_err++;
      if (i[INST_ACC] !== prev_rd) acc_err++;
      if (i[INST_OFIFO_RD] && !prev_v) trk_err++;
      c = "";
      if (i[INST_L0_WR]) c = "W";
      else if (i[INST_KLOAD]) c = "P";
      else if (i[INST_EXEC]) c = "E";
      else if (i[INST_OFIFO_RD]) c = "R";
      if (c != "" && c != last) begin sig = {sig, c}; last = c; end
      if (i[INST_L0_WR]) begin
        wq.push_back(int'(mem_addr));
        if (stalled && stall_gap < 0) stall_gap = cyc - trig_cyc - 1;
      end
      if (i[INST_KLOAD]) pcur++; else if (pcur > 0) begin pr.push_back(pcur); pcur = 0; end
      if (i[INST_EXEC])  ecur++; else if (ecur > 0) begin er.push_back(ecur); ecur = 0; end
      if (i[INST_OFIFO_RD]) nrd++;
      if (i[INST_ACC]) nacc++;
      if (done === 1'b1) ndone++;
      if (stall_left > 0) begin
        if (i[INST_L0_WR] !== 1'b0 || int'(mem_addr) != stall_addr) stall_err++;
        stall_left--;
      end
      if (post >= 0) begin
        if (busy !== 1'b0 || done !== 1'b0) post_err++;
        post++;
      end else if (done === 1'b1) begin
        post = 0;
      end
      if (post >= 3) break;
      // drive inputs for the next edge
      if (stall_after > 0 && !stalled && i[INST_L0_WR] && wq.size() == stall_after) begin
        stalled = 1'b1; drive_left = 3; stall_left = 3;
        stall_addr = int'(mem_addr); trig_cyc = cyc;
      end
      if (drive_left > 0) begin l0_full = 1'b1; drive_left--; end
      else l0_full = 1'b0;
      ofifo_valid = toggle ? ~ofifo_valid : 1'b1;
      if (cyc == restart_at) begin start = 1'b1; num_act = 8'd9; os_req = 1'b1; end
      else start = 1'b0;
      prev_v = ofifo_valid;
      prev_rd = i[INST_OFIFO_RD];
      @(negedge clk);
    end
    if (post < 3) timeout = 1;
    if (pcur > 0) pr.push_back(pcur);
    if (ecur > 0) er.push_back(ecur);
    start = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b0;
  endtask

  // Address stream: col weight words then num_act activation words per kij.
  task automatic chk_addrs(input string tag, input int na, input int nk,
                           input int wb, input int xb);
    int exp[$];
    int err;
    for (int k = 0; k < nk; k++) begin
      for (int j = 0; j < 8; j++)  exp.push_back((wb + k * 8 + j) % 2048);
      for (int j = 0; j < na; j++) exp.push_back((xb + k * na + j) % 2048);
    end
    chk({tag, "_wr_count"}, wq.size(), exp.size());
    err = 0;
    for (int j = 0; j < wq.size() && j < exp.size(); j++)
      if (wq[j] != exp[j]) err++;
    chk({tag, "_wr_addr_err"}, err, 0);
  endtask

  task automatic chk_runs(input string tag, input int nk, input int plen, input int elen);
    int err;
    chk({tag, "_kpush_phases"}, pr.size(), nk);
    chk({tag, "_exec_phases"}, er.size(), nk);
    err = 0;
    foreach (pr[j]) if (pr[j] != plen) err++;
    foreach (er[j]) if (er[j] != elen) err++;
    chk({tag, "_phase_len_err"}, err, 0);
  endtask

  task automatic chk_common(input string tag);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_done_pulses"}, ndone, 1);
    chk({tag, "_illegal_bits"}, bad_bits, 0);
    chk({tag, "_mode_bit_err"}, mode_err, 0);
    chk({tag, "_acc_align_err"}, acc_err, 0);
    chk({tag, "_post_done_err"}, post_err, 0);
  endtask

  initial begin
    int seen;
    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_inst", inst, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Basic WS run
    run(0, 4, 1, 0, 16, 0, 0, -1);
    chk_common("ws1");
    chk_addrs("ws1", 4, 1, 0, 16);
    chk("ws1_first_w", wq.size() > 0 ? wq[0] : -1, 0);
    chk("ws1_last_x", wq.size() == 12 ? wq[11] : -1, 19);
    chk_runs("ws1", 1, 15, 18);
    chk_s("ws1_order", sig, "WPWER");
    chk("ws1_reads", nrd, 4);
    chk("ws1_accs", nacc, 4);

    // l0_full stall for 3 cycles after the third weight write
    run(0, 4, 1, 0, 16, 3, 0, -1);
    chk_common("stall");
    chk_addrs("stall", 4, 1, 0, 16);
    chk("stall_gap", stall_gap, 3);
    chk("stall_frozen_err", stall_err, 0);
    chk_s("stall_order", sig, "WPWER");

    // Three kernel positions in WS
    run(0, 4, 3, 0, 16, 0, 0, -1);
    chk_common("kij3");
    chk_addrs("kij3", 4, 3, 0, 16);
    chk("kij3_wbase0", wq.size() == 36 ? wq[0] : -1, 0);
    chk("kij3_wbase1", wq.size() == 36 ? wq[12] : -1, 8);
    chk("kij3_wbase2", wq.size() == 36 ? wq[24] : -1, 16);
    chk_runs("kij3", 3, 15, 18);
    chk_s("kij3_order", sig, "WPWERWPWERWPWER");
    chk("kij3_accs", nacc, 12);

    // OS request, two kernel positions
    run(1, 4, 2, 0, 16, 0, 0, -1);
    chk_common("os");
    chk_addrs("os", 4, 2, 0, 16);
    chk_runs("os", 2, 15, 18);
    chk_s("os_order", sig, OS_EN ? "WPWEWPWER" : "WPWERWPWER");
    chk("os_accs", nacc, OS_EN ? 4 : 8);

    // Reset during EXEC
    @(negedge clk);
    os_req = 1'b0; num_act = 8'd4; num_kij = 8'd2; w_base = '0; x_base = 11'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; ofifo_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (inst[INST_EXEC] === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("rstx_reached_exec", seen, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstx_inst", inst, 0);
    chk("rstx_busy", busy, 0);
    chk("rstx_addr", mem_addr, 0);
    chk("rstx_done", done, 0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen++;
      @(negedge clk);
    end
    chk("rstx_quiet", seen, 0);
    ofifo_valid = 1'b0;
    run(0, 4, 1, 0, 16, 0, 0, -1);
    chk_common("rstx_rerun");
    chk_addrs("rstx_rerun", 4, 1, 0, 16);
    chk("rstx_rerun_accs", nacc, 4);

    // Start while busy, ofifo_valid toggling in DRAIN
    run(0, 4, 1, 0, 16, 0, 1, 20);
    chk_common("tog");
    chk_addrs("tog", 4, 1, 0, 16);
    chk_runs("tog", 1, 15, 18);
    chk("tog_track_err", trk_err, 0);
    chk("tog_reads", nrd, 4);
    chk("tog_accs", nacc, 4);

    // num_act=0/num_kij=0 become 1; addresses wrap at 2048
    run(0, 0, 0, 2044, 2047, 0, 0, -1);
    chk_common("zero");
    chk_addrs("zero", 1, 1, 2044, 2047);
    chk("zero_wrap_w", wq.size() == 9 ? wq[4] : -1, 0);
    chk_runs("zero", 1, 15, 15);
    chk("zero_reads", nrd, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
